vec3_normalize_seq: RTL and testbench
=====================================

# vec3_normalize_seq

Multi-cycle Q8.4 3D vector normalizer. It computes each result with one shared divider and one square-root unit, trading latency for area against the fully combinational normalize path. It sits between the ray-generation stage and the shading/intersection stages. It accepts one vector per transaction over a valid/ready handshake and returns the unit vector plus status flags.

## Interface
- WIDTH, 12, signed Q8.4 word width (4 fractional bits); MAX_Q = 2^(WIDTH-1)-1, MIN_Q = -2^(WIDTH-1)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset; one clock domain only
- in_valid  in  1  request valid
- in_ready  out  1  high only in IDLE
- in_x, in_y, in_z  in  WIDTH each  signed Q8.4 input vector
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- out_x, out_y, out_z  out  WIDTH each  signed Q8.4 normalized vector
- out_zero_mag  out  1  magnitude evaluated to 0; vector outputs forced to 0
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, MAG, SQRT, DIVX, DIVY, DIVZ, DONE.
- IDLE: in_ready=1. On in_valid, capture in_x/y/z into internal registers and go to MAG.
- MAG: register mag2 = sum over x,y,z of (v*v) >>> 4.
  - Held unsigned in 2*WIDTH+2 bits.
  - No truncation or wrap; always ≥ 0.
  - Go to SQRT.
- SQRT: mag = floor(sqrt(mag2 << 4)), saturated to MAX_Q. Register mag.
  - If mag == 0: clear out_x/y/z to 0, set out_zero_mag=1, go to DONE.
  - Else: set out_zero_mag=0, go to DIVX.
- DIVX, DIVY, DIVZ: one shared divider, one component per state, result registered into out_x, out_y, out_z in that order.
  - Quotient = (v <<< 4) / mag, truncating toward zero.
  - Saturated to [MIN_Q, MAX_Q]; the divisor is never 0.
  - DIVZ goes to DONE.
- DONE: out_valid=1 and all out_* stable. When out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. The captured inputs are independent of in_x/y/z changing after the accept.
- No result is ever dropped. out_valid stays asserted indefinitely while out_ready=0.

## Timing
- Reset (async, any state, including mid-operation): state=IDLE.
  - in_ready=1, out_valid=0, busy=0, out_zero_mag=0, out_x/y/z=0.
  - Any in-flight operation is discarded.
- Accept on edge N (in_valid && in_ready), normal path:
  - MAG during N→N+1, SQRT N+1→N+2, DIVX N+2→N+3, DIVY N+3→N+4, DIVZ N+4→N+5.
  - out_valid=1 after edge N+5 (5-cycle latency).
- Zero-magnitude path: out_valid=1 after edge N+2 (2-cycle latency).
- Result accepted on edge M (out_valid && out_ready): out_valid=0 and in_ready=1 after M.
  - Next accept is possible at edge M+1 at the earliest.
  - Best-case throughput is one vector per 7 cycles.
- out_ready high before DONE has no effect.
- in_valid held high continuously causes back-to-back transactions, each captured only in IDLE.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- Reset then (16,0,0) [1.0,0,0], out_ready=1 → out_valid 5 cycles after accept. Output (16,0,0), out_zero_mag=0, then in_ready=1 the next cycle.
- (48,64,0) [3,4,0] → mag2=400, mag=80. Output (9,12,0) (truncated 9.6, 12.8).
- (-48,-64,0) → output (-9,-12,0), confirming truncation toward zero.
- (0,0,0), and also (1,0,0) where mag2=0 → out_valid 2 cycles after accept. Output (0,0,0), out_zero_mag=1.
- (2047,0,0) → mag2=261888, mag=2046, no wrap. Output (16,0,0).
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored.
  - Then out_ready=1 → one handshake, next vector accepted the following cycle.
  - Separately, assert rst during DIVY → immediate IDLE with all outputs at reset values and no stale out_valid afterwards.

Source files
------------

// File: rtl/vec3_normalize_seq.sv
// vec3_normalize_seq
//   Multi-cycle Q8.4 3D vector normalizer. A single square-root unit and a
//   single divider are time-shared across the vector components.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    request handshake; in_ready high only in IDLE
//   in_x, in_y, in_z     signed Q8.4 input vector
//   out_valid/out_ready  result handshake; result held until accepted
//   out_x, out_y, out_z  signed Q8.4 normalized vector
//   out_zero_mag         magnitude evaluated to 0, vector outputs forced to 0
//   busy                 high in every state except IDLE
//
// state | meaning
// IDLE  | waiting for a request, inputs captured on accept
// MAG   | register squared magnitude
// SQRT  | register saturated magnitude, detect zero magnitude
// DIVX  | out_x = x / mag
// DIVY  | out_y = y / mag
// DIVZ  | out_z = z / mag
// DONE  | result presented until out_ready
module vec3_normalize_seq #(
  parameter int WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_x,
  input  logic signed [WIDTH-1:0] in_y,
  input  logic signed [WIDTH-1:0] in_z,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_x,
  output logic signed [WIDTH-1:0] out_y,
  output logic signed [WIDTH-1:0] out_z,
  output logic                    out_zero_mag,
  output logic                    busy
);

  localparam int MW = 2*WIDTH + 2;   // squared magnitude width
  localparam int RW = MW + 4;        // sqrt radicand width (mag2 << 4)
  localparam int SW = RW / 2;        // sqrt root width
  localparam int DW = WIDTH + 4;     // divider width (v <<< 4)
  localparam logic signed [DW-1:0] Q_HI = DW'(2**(WIDTH-1) - 1);
  localparam logic signed [DW-1:0] Q_LO = DW'(-(2**(WIDTH-1)));

  typedef enum logic [2:0] {IDLE, MAG, SQRT, DIVX, DIVY, DIVZ, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] vx, vy, vz;
  logic [MW-1:0]           mag2_q;
  logic [WIDTH-1:0]        mag_q;

  // squared terms; products are never negative so >>> 4 is a plain slice
  logic signed [2*WIDTH-1:0] px, py, pz;
  logic [MW-1:0]             mag2_nxt;

  assign px = vx * vx;
  assign py = vy * vy;
  assign pz = vz * vz;
  assign mag2_nxt = {{(MW-2*WIDTH+4){1'b0}}, px[2*WIDTH-1:4]}
                  + {{(MW-2*WIDTH+4){1'b0}}, py[2*WIDTH-1:4]}
                  + {{(MW-2*WIDTH+4){1'b0}}, pz[2*WIDTH-1:4]};

  // digit-by-digit integer square root of mag2 << 4
  logic [RW-1:0]   rad;
  logic [RW+1:0]   rem;
  logic [RW+1:0]   trial;
  logic [SW-1:0]   root;
  logic [WIDTH-1:0] mag_nxt;

  assign rad = {mag2_q, 4'b0000};

  always_comb begin
    rem   = '0;
    trial = '0;
    root  = '0;
    for (int i = SW-1; i >= 0; i--) begin
      rem   = {rem[RW-1:0], rad[2*i +: 2]};
      trial = {{(RW-SW){1'b0}}, root, 2'b01};
      if (rem >= trial) begin
        rem  = rem - trial;
        root = {root[SW-2:0], 1'b1};
      end else begin
        root = {root[SW-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    if (|root[SW-1:WIDTH-1])
      mag_nxt = {1'b0, {(WIDTH-1){1'b1}}};
    else
      mag_nxt = root[WIDTH-1:0];
  end

  // shared divider; operand picked by the current divide state
  logic signed [WIDTH-1:0] div_sel;
  logic signed [DW-1:0]    div_num, div_den, div_q;
  logic signed [WIDTH-1:0] div_sat;

  always_comb begin
    case (state)
      DIVY:    div_sel = vy;
      DIVZ:    div_sel = vz;
      default: div_sel = vx;
    endcase
    div_num = $signed({div_sel, 4'b0000});
    div_den = $signed({4'b0000, mag_q});
    div_q   = div_num / div_den;
    if (div_q > Q_HI)
      div_sat = Q_HI[WIDTH-1:0];
    else if (div_q < Q_LO)
      div_sat = Q_LO[WIDTH-1:0];
    else
      div_sat = div_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAG;
      MAG:     state_nxt = SQRT;
      SQRT:    state_nxt = (mag_nxt == '0) ? DONE : DIVX;
      DIVX:    state_nxt = DIVY;
      DIVY:    state_nxt = DIVZ;
      DIVZ:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vx           <= '0;
      vy           <= '0;
      vz           <= '0;
      mag2_q       <= '0;
      mag_q        <= '0;
      out_x        <= '0;
      out_y        <= '0;
      out_z        <= '0;
      out_zero_mag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          vx <= in_x;
          vy <= in_y;
          vz <= in_z;
        end
        MAG:  mag2_q <= mag2_nxt;
        SQRT: begin
          mag_q <= mag_nxt;
          if (mag_nxt == '0) begin
            out_x        <= '0;
            out_y        <= '0;
            out_z        <= '0;
            out_zero_mag <= 1'b1;
          end else begin
            out_zero_mag <= 1'b0;
          end
        end
        DIVX: out_x <= div_sat;
        DIVY: out_y <= div_sat;
        DIVZ: out_z <= div_sat;
        default: ;
      endcase
    end
  end

  // decoded straight from the state register, no input-to-output path
  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_vec3_normalize_seq.sv
// Self-checking bench for vec3_normalize_seq: directed vectors, random
// vectors against an integer reference model, backpressure and mid-flight reset.
module tb_vec3_normalize_seq;

  localparam int WIDTH = 12;
  localparam int MAXQ  = 2**(WIDTH-1) - 1;
  localparam int MINQ  = -(2**(WIDTH-1));

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_x, in_y, in_z;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_x, out_y, out_z;
  logic                    out_zero_mag;
  logic                    busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vec3_normalize_seq #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_z         (in_z),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_z        (out_z),
    .out_zero_mag (out_zero_mag),
    .busy         (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > MAXQ) return MAXQ;
    if (v < MINQ) return MINQ;
    return int'(v);
  endfunction

  // reference: plain integer arithmetic straight from the normalize rules
  function automatic void model(input int x, input int y, input int z,
                                output int ex, output int ey, output int ez,
                                output int zf, output int lat);
    longint m2, r, m;
    m2 = longint'(x*x)/16 + longint'(y*y)/16 + longint'(z*z)/16;
    r  = m2 * 16;
    m  = 0;
    while ((m+1)*(m+1) <= r) m++;
    if (m > MAXQ) m = MAXQ;
    if (m == 0) begin
      ex = 0; ey = 0; ez = 0; zf = 1; lat = 2;
    end else begin
      ex = sat(longint'(x*16) / m);
      ey = sat(longint'(y*16) / m);
      ez = sat(longint'(z*16) / m);
      zf = 0; lat = 5;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) check("in_ready_timeout", 0, 1);
  endtask

  // waits for out_valid, returns the number of edges taken
  task automatic wait_result(input bit rand_rdy, output int cnt);
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      tick();
      cnt++;
    end
    out_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int x, input int y, input int z,
                              input int cnt);
    int ex, ey, ez, zf, lat;
    model(x, y, z, ex, ey, ez, zf, lat);
    check({tag, "_lat"}, cnt, lat);
    check({tag, "_x"}, int'(out_x), ex);
    check({tag, "_y"}, int'(out_y), ey);
    check({tag, "_z"}, int'(out_z), ez);
    check({tag, "_zero"}, int'(out_zero_mag), zf);
  endtask

  task automatic run_vec(input string tag, input int x, input int y, input int z,
                         input bit rand_rdy);
    int cnt;
    wait_ready();
    in_valid = 1'b1;
    in_x = WIDTH'(x); in_y = WIDTH'(y); in_z = WIDTH'(z);
    tick();
    in_valid = 1'b0;
    // scramble inputs to prove the vector was captured at accept
    in_x = WIDTH'($urandom); in_y = WIDTH'($urandom); in_z = WIDTH'($urandom);
    check({tag, "_busy"}, int'(busy), 1);
    wait_result(rand_rdy, cnt);
    check_result(tag, x, y, z, cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_clr"}, int'(out_valid), 0);
    check({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    int cnt, hx, hy, hz;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_zero", int'(out_zero_mag), 0);
    check("rst_out_x", int'(out_x), 0);
    @(negedge clk) rst = 1'b0;
    tick();

    run_vec("unit_x", 16, 0, 0, 1'b0);
    run_vec("v345", 48, 64, 0, 1'b0);
    run_vec("v345_neg", -48, -64, 0, 1'b0);
    run_vec("zero", 0, 0, 0, 1'b0);
    run_vec("tiny", 1, 0, 0, 1'b0);
    run_vec("big_x", 2047, 0, 0, 1'b0);
    run_vec("min_all", -2048, -2048, -2048, 1'b0);
    run_vec("mixed", -2048, 2047, 5, 1'b1);

    for (int i = 0; i < 30; i++) begin
      int rng, x, y, z;
      rng = (i % 3 == 0) ? 8 : ((i % 3 == 1) ? 200 : 2048);
      x = int'($urandom_range(0, 2*rng - 1)) - rng;
      y = int'($urandom_range(0, 2*rng - 1)) - rng;
      z = int'($urandom_range(0, 2*rng - 1)) - rng;
      run_vec("rand", x, y, z, 1'b1);
    end

    // backpressure: hold result 10 cycles while a new request waits
    wait_ready();
    in_valid = 1'b1; in_x = 12'sd48; in_y = 12'sd64; in_z = 12'sd0;
    tick();
    in_valid = 1'b0;
    wait_result(1'b0, cnt);
    check_result("bp_first", 48, 64, 0, cnt);
    hx = 100; hy = -5; hz = 7;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_x = WIDTH'(hx); in_y = WIDTH'(hy); in_z = WIDTH'(hz);
      tick();
      check("bp_hold_x", int'(out_x), 9);
      check("bp_hold_y", int'(out_y), 12);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_busy", int'(busy), 1);
    wait_result(1'b0, cnt);
    check_result("bp_next", hx, hy, hz, cnt);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // reset while the divider sequence is in DIVY
    wait_ready();
    in_valid = 1'b1; in_x = 12'sd16; in_y = 12'sd16; in_z = 12'sd16;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("divy_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_zero", int'(out_zero_mag), 0);
    check("mid_rst_x", int'(out_x), 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_no_valid", int'(out_valid), 0);
    end
    run_vec("after_rst", -30, 40, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected finish");
    $fatal(1);
  end

endmodule
